cpu_pmp: RTL

Parametrised, software-programmable Physical Memory Protection unit for the RISC-V core, succeeding the fixed, hard-wired PMP map. It holds NUM_ENTRIES writable pmpcfg/pmpaddr entries and serves NUM_PORTS independent registered permission lookups (fetch, load/store, ...). It sits beside cpu_csr: the CSR unit forwards PMP-range CSR accesses to this block, and the pipeline stages query the lookup ports.

---
 rtl/cpu_pmp_pkg.sv | 39 +++
 rtl/cpu_pmp_match.sv | 31 +++
 rtl/cpu_pmp.sv | 128 ++++++++++++
 3 files changed

// File: rtl/cpu_pmp_pkg.sv
// Shared PMP types, CSR addresses and the WARL legalisation rule for pmpcfg bytes.
// Imported by the lookup matcher and the PMP top.
package cpu_pmp_pkg;

  typedef logic [11:0] csr_t;

  typedef enum logic [1:0] {
    PMPCFG_A_OFF   = 2'b00,
    PMPCFG_A_TOR   = 2'b01,
    PMPCFG_A_NA4   = 2'b10,
    PMPCFG_A_NAPOT = 2'b11
  } pmpcfg_a_t;

  typedef struct packed {
    logic      l;
    logic [1:0] rsvd;
    pmpcfg_a_t a;
    logic      x;
    logic      w;
    logic      r;
  } pmpcfg_t;

  localparam csr_t        CSR_PMPCFG0     = 12'h3A0;
  localparam csr_t        CSR_PMPADDR0    = 12'h3B0;
  localparam int unsigned PMP_MAX_ENTRIES = 16;

  // Reserved bits read as zero; the reserved R=0,W=1 combination collapses to no access.
  function automatic pmpcfg_t pmpcfg_legalize(input logic [7:0] wdata);
    pmpcfg_t cfg;
    cfg      = pmpcfg_t'(wdata);
    cfg.rsvd = '0;
    if (!cfg.r && cfg.w) begin
      cfg.x = 1'b0;
      cfg.w = 1'b0;
    end
    return cfg;
  endfunction

endpackage

// File: rtl/cpu_pmp_match.sv
// Single-entry PMP address matcher: decides whether one word address falls inside
// the region described by one entry's mode, address and predecessor address.
module cpu_pmp_match
  import cpu_pmp_pkg::*;
(
  input  pmpcfg_t     cfg_i,
  input  logic [29:0] addr_i,
  input  logic [29:0] prev_addr_i,
  input  logic [29:0] lookup_addr_i,
  output logic        hit_o
);

  logic [29:0] napot_mask;
  logic        cfg_unused;

  assign cfg_unused = ^{cfg_i.l, cfg_i.rsvd, cfg_i.x, cfg_i.w, cfg_i.r};

  // Trailing ones plus the first zero above them are don't-care bits; all ones clears the mask.
  assign napot_mask = ~(addr_i ^ (addr_i + 30'd1));

  always_comb begin
    hit_o = 1'b0;
    case (cfg_i.a)
      PMPCFG_A_TOR:   hit_o = (lookup_addr_i >= prev_addr_i) && (lookup_addr_i < addr_i);
      PMPCFG_A_NA4:   hit_o = (lookup_addr_i == addr_i);
      PMPCFG_A_NAPOT: hit_o = ((lookup_addr_i ^ addr_i) & napot_mask) == '0;
      default:        hit_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_pmp.sv
// Software-programmable PMP: pmpcfg/pmpaddr CSR storage with WARL write rules and
// NUM_PORTS independent single-cycle registered permission lookups.
module cpu_pmp
  import cpu_pmp_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES  = 16,
  parameter int unsigned NUM_PORTS    = 2,
  parameter logic [2:0]  NO_MATCH_RWX = 3'b000
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  csr_t                        read_addr_i,
  input  logic                        read_enable_i,
  output logic [31:0]                 read_data_o,
  input  csr_t                        write_addr_i,
  input  logic [31:0]                 write_data_i,
  input  logic                        write_enable_i,
  input  logic [NUM_PORTS-1:0]        lookup_valid_i,
  input  logic [NUM_PORTS-1:0][31:0]  lookup_addr_i,
  output logic [NUM_PORTS-1:0]        lookup_valid_o,
  output logic [NUM_PORTS-1:0][2:0]   lookup_rwx_o,
  output logic [NUM_PORTS-1:0][3:0]   lookup_match_o
);

  pmpcfg_t     cfg_r     [NUM_ENTRIES];
  logic [29:0] addr_r    [NUM_ENTRIES];
  logic [29:0] prev_addr [NUM_ENTRIES];

  logic [NUM_ENTRIES-1:0]                 addr_locked;
  logic [NUM_PORTS-1:0][NUM_ENTRIES-1:0]  hit;
  logic [NUM_PORTS-1:0]                   found;
  logic [NUM_PORTS-1:0][2:0]              rwx_d;
  logic [NUM_PORTS-1:0][3:0]              match_d;
  logic [31:0]                            read_data_d;
  logic [NUM_PORTS-1:0]                   lookup_addr_unused;

  // An address is frozen by its own lock or by a locked TOR entry above that uses it as base.
  always_comb begin
    for (int unsigned i = 0; i + 1 < NUM_ENTRIES; i++) begin
      addr_locked[i] = cfg_r[i].l | (cfg_r[i+1].l & (cfg_r[i+1].a == PMPCFG_A_TOR));
    end
    addr_locked[NUM_ENTRIES-1] = cfg_r[NUM_ENTRIES-1].l;
  end

  always_comb begin
    prev_addr[0] = '0;
    for (int unsigned i = 1; i < NUM_ENTRIES; i++) begin
      prev_addr[i] = addr_r[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
        cfg_r[i]  <= '0;
        addr_r[i] <= '0;
      end
    end else if (write_enable_i) begin
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
        if ((write_addr_i == CSR_PMPCFG0 + csr_t'(i / 4)) && !cfg_r[i].l) begin
          cfg_r[i] <= pmpcfg_legalize(write_data_i[8*(i%4) +: 8]);
        end
        if ((write_addr_i == CSR_PMPADDR0 + csr_t'(i)) && !addr_locked[i]) begin
          addr_r[i] <= write_data_i[29:0];
        end
      end
    end
  end

  always_comb begin
    read_data_d = '0;
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      if (read_addr_i == CSR_PMPCFG0 + csr_t'(i / 4)) begin
        read_data_d[8*(i%4) +: 8] = cfg_r[i];
      end
      if (read_addr_i == CSR_PMPADDR0 + csr_t'(i)) begin
        read_data_d = {2'b00, addr_r[i]};
      end
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign lookup_addr_unused[p] = ^lookup_addr_i[p][1:0];
    for (genvar e = 0; e < NUM_ENTRIES; e++) begin : g_entry
      cpu_pmp_match u_match (
        .cfg_i         (cfg_r[e]),
        .addr_i        (addr_r[e]),
        .prev_addr_i   (prev_addr[e]),
        .lookup_addr_i (lookup_addr_i[p][31:2]),
        .hit_o         (hit[p][e])
      );
    end
  end

  // Lowest-numbered hit wins.
  always_comb begin
    found   = '0;
    rwx_d   = '0;
    match_d = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      rwx_d[p] = NO_MATCH_RWX;
      for (int unsigned e = 0; e < NUM_ENTRIES; e++) begin
        if (hit[p][e] && !found[p]) begin
          found[p]   = 1'b1;
          rwx_d[p]   = {cfg_r[e].x, cfg_r[e].w, cfg_r[e].r};
          match_d[p] = 4'(e);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      read_data_o    <= '0;
      lookup_valid_o <= '0;
      lookup_rwx_o   <= '0;
      lookup_match_o <= '0;
    end else begin
      read_data_o    <= read_enable_i ? read_data_d : '0;
      lookup_valid_o <= lookup_valid_i;
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        lookup_rwx_o[p]   <= lookup_valid_i[p] ? rwx_d[p]   : '0;
        lookup_match_o[p] <= lookup_valid_i[p] ? match_d[p] : '0;
      end
    end
  end

endmodule
